// File: rtl/agc_gain_controller.sv
// AGC decision stage: windowed peak |sample| measurement driving a clamped
// 6-bit gain index, with settle blanking after each gain step and a lock
// indication after consecutive in-band windows.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | loop disabled, gain_array held
// MEASURE | accumulating peak magnitude over WINDOW_LEN valid samples
// DECIDE  | one cycle: apply gain step rules to the final window peak
// SETTLE  | blank SETTLE_CYCLES cycles after a gain change
// LOCKED  | in-band for LOCK_WINDOWS windows, gain frozen
module agc_gain_controller #(
    parameter int DATA_W        = 8,
    parameter int WINDOW_LEN    = 64,
    parameter int SETTLE_CYCLES = 16,
    parameter int GAIN_MAX      = 38,
    parameter int GAIN_INIT     = 38,
    parameter int COARSE_STEP   = 4,
    parameter int LOCK_WINDOWS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              agc_en,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DATA_W-2:0] thr_hi,
    input  logic [DATA_W-2:0] thr_lo,
    output logic [5:0]        gain_array,
    output logic              gain_update,
    output logic              locked
);

    localparam int WIN_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int IB_W  = $clog2(LOCK_WINDOWS + 1);

    localparam logic [DATA_W-2:0] SAT      = '1;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [IB_W-1:0]   IB_LOCK  = IB_W'(LOCK_WINDOWS);
    localparam logic [5:0]        G_MAX    = 6'(GAIN_MAX);
    localparam logic [5:0]        G_INIT   = 6'(GAIN_INIT);
    localparam logic [5:0]        G_COARSE = 6'(COARSE_STEP);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MEASURE = 3'd1,
        DECIDE  = 3'd2,
        SETTLE  = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-2:0] peak;
    logic [DATA_W-2:0] mag;
    logic [DATA_W-1:0] adc_neg;
    logic [WIN_W-1:0]  win_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic [IB_W-1:0]   inband_cnt;
    logic [IB_W-1:0]   inband_inc;
    logic [5:0]        gain_new;
    logic              inband_hit;

    assign adc_neg    = (~adc_data) + ONE;
    assign inband_inc = inband_cnt + IB_W'(1);

    // Sample magnitude; the most negative code has no positive twin, so it saturates.
    always_comb begin
        mag = adc_data[DATA_W-2:0];
        if (adc_data == MOST_NEG) begin
            mag = SAT;
        end else if (adc_data[DATA_W-1]) begin
            mag = adc_neg[DATA_W-2:0];
        end
    end

    // Gain step rules in priority order; over-threshold is tested before
    // under-threshold so inverted thresholds resolve toward lowering gain.
    always_comb begin
        gain_new   = gain_array;
        inband_hit = 1'b0;
        if (peak == SAT) begin
            gain_new = (gain_array > G_COARSE) ? gain_array - G_COARSE : 6'd0;
        end else if (peak > thr_hi) begin
            gain_new = (gain_array != 6'd0) ? gain_array - 6'd1 : 6'd0;
        end else if (peak < thr_lo) begin
            gain_new = (gain_array < G_MAX) ? gain_array + 6'd1 : G_MAX;
        end else begin
            inband_hit = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; disable overrides everything, including a pending DECIDE.
    always_comb begin
        state_nx = state;
        if (!agc_en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = MEASURE;
                MEASURE: if (adc_valid && win_cnt == WIN_LAST) state_nx = DECIDE;
                DECIDE: begin
                    if (inband_hit && inband_inc == IB_LOCK) begin
                        state_nx = LOCKED;
                    end else if (gain_new != gain_array) begin
                        state_nx = SETTLE;
                    end else begin
                        state_nx = MEASURE;
                    end
                end
                SETTLE:  if (settle_cnt == '0) state_nx = MEASURE;
                LOCKED:  state_nx = LOCKED;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Datapath: peak tracking, window/settle/in-band counters, gain and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_array  <= G_INIT;
            gain_update <= 1'b0;
            locked      <= 1'b0;
            peak        <= '0;
            win_cnt     <= '0;
            settle_cnt  <= '0;
            inband_cnt  <= '0;
        end else begin
            gain_update <= 1'b0;
            locked      <= (state_nx == LOCKED);
            if (!agc_en) begin
                peak       <= '0;
                win_cnt    <= '0;
                settle_cnt <= '0;
                inband_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        peak    <= '0;
                        win_cnt <= '0;
                    end
                    MEASURE: begin
                        if (adc_valid) begin
                            if (mag > peak) peak <= mag;
                            win_cnt <= (win_cnt == WIN_LAST) ? '0 : win_cnt + WIN_W'(1);
                        end
                    end
                    DECIDE: begin
                        gain_array  <= gain_new;
                        gain_update <= (gain_new != gain_array);
                        inband_cnt  <= inband_hit ? inband_inc : '0;
                        peak        <= '0;
                        win_cnt     <= '0;
                        settle_cnt  <= SET_LOAD;
                    end
                    SETTLE: begin
                        peak    <= '0;
                        win_cnt <= '0;
                        if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_agc_gain_controller.sv
// Directed bench for agc_gain_controller with default parameters.
module tb_agc_gain_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       agc_en;
    logic       adc_valid;
    logic [7:0] adc_data;
    logic [6:0] thr_hi;
    logic [6:0] thr_lo;
    logic [5:0] gain_array;
    logic       gain_update;
    logic       locked;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int exp_gain;
    int pulses_ref;

    agc_gain_controller dut (
        .clk         (clk),
        .rst         (rst),
        .agc_en      (agc_en),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .thr_hi      (thr_hi),
        .thr_lo      (thr_lo),
        .gain_array  (gain_array),
        .gain_update (gain_update),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    // Count gain_update high cycles, sampled mid-cycle.
    always @(negedge clk) if (gain_update === 1'b1) pulse_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // 64 valid samples of constant value; leaves the DUT in DECIDE.
    task automatic window(input logic [7:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        repeat (64) tick();
        adc_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (16) tick();
    endtask

    initial begin
        rst       = 1'b1;
        agc_en    = 1'b0;
        adc_valid = 1'b0;
        adc_data  = 8'd0;
        thr_lo    = 7'd20;
        thr_hi    = 7'd100;
        #22;
        check("reset_gain", gain_array, 38);
        check("reset_update", gain_update, 0);
        check("reset_locked", locked, 0);
        rst = 1'b0;
        tick();

        // Low-level window at max gain: clamped, no pulse.
        agc_en = 1'b1;
        tick();
        window(8'd10);
        tick();
        check("t1_gain", gain_array, 38);
        check("t1_update", gain_update, 0);
        check("t1_pulses", pulse_cnt, 0);

        // Saturated input: coarse steps down to 0.
        exp_gain = 38;
        for (int k = 0; k < 10; k++) begin
            window(8'h80);
            tick();
            exp_gain = (exp_gain > 4) ? exp_gain - 4 : 0;
            check("t2_gain_step", gain_array, exp_gain);
            check("t2_update", gain_update, 1);
            settle();
        end
        window(8'h80);
        tick();
        check("t2_gain_floor", gain_array, 0);
        check("t2_no_pulse", gain_update, 0);
        check("t2_pulses", pulse_cnt, 10);

        // Walk the gain up to 20 with quiet windows.
        for (int k = 1; k <= 20; k++) begin
            window(8'd10);
            tick();
            check("ramp_gain", gain_array, k);
            settle();
        end

        // One window with peak 90 above thr_hi=80: step down by one.
        thr_lo    = 7'd40;
        thr_hi    = 7'd80;
        adc_valid = 1'b1;
        adc_data  = 8'd50;
        repeat (63) tick();
        adc_data = 8'd90;
        tick();
        adc_valid = 1'b0;
        check("t4_decide_hold", gain_array, 20);
        tick();
        check("t4_gain", gain_array, 19);
        check("t4_update", gain_update, 1);
        // Saturating samples during settle must be discarded.
        adc_valid = 1'b1;
        adc_data  = 8'd127;
        settle();

        // Four in-band windows of +/-60 lock the loop.
        for (int w = 1; w <= 4; w++) begin
            adc_valid = 1'b1;
            for (int i = 0; i < 64; i++) begin
                adc_data = i[0] ? 8'hC4 : 8'd60;
                tick();
            end
            adc_valid = 1'b0;
            tick();
            check("t3_gain", gain_array, 19);
            check("t3_update", gain_update, 0);
            check("t3_locked", locked, (w == 4) ? 1 : 0);
        end
        pulses_ref = pulse_cnt;
        adc_valid  = 1'b1;
        adc_data   = 8'd127;
        repeat (80) tick();
        check("t3_frozen_gain", gain_array, 19);
        check("t3_still_locked", locked, 1);
        check("t3_no_pulses", pulse_cnt, pulses_ref);

        // Disable clears lock and holds gain.
        agc_en    = 1'b0;
        adc_valid = 1'b0;
        tick();
        check("dis_locked", locked, 0);
        check("dis_gain", gain_array, 19);

        // Every-other-cycle valid: 64th valid sample arrives at cycle 126.
        agc_en = 1'b1;
        tick();
        for (int i = 0; i < 126; i++) begin
            adc_valid = ~i[0];
            adc_data  = i[0] ? 8'h80 : 8'd10;
            tick();
        end
        adc_valid = 1'b1;
        adc_data  = 8'd10;
        tick();
        adc_valid = 1'b0;
        check("t5_not_yet", gain_array, 19);
        check("t5_not_yet_upd", gain_update, 0);
        tick();
        check("t5_gain", gain_array, 20);
        check("t5_update", gain_update, 1);
        settle();

        // agc_en dropped in the DECIDE cycle: decision discarded.
        window(8'd10);
        agc_en = 1'b0;
        tick();
        check("t6a_gain", gain_array, 20);
        check("t6a_update", gain_update, 0);
        check("t6a_locked", locked, 0);
        agc_en = 1'b1;
        tick();
        window(8'd10);
        tick();
        check("t6a_restart_gain", gain_array, 21);
        check("t6a_restart_upd", gain_update, 1);
        settle();

        // Asynchronous reset mid-window.
        adc_valid = 1'b1;
        adc_data  = 8'h80;
        repeat (30) tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6b_gain", gain_array, 38);
        check("t6b_locked", locked, 0);
        check("t6b_update", gain_update, 0);
        #1;
        rst = 1'b0;
        tick();
        window(8'h80);
        check("t6b_full_window", gain_array, 38);
        tick();
        check("t6b_gain_after", gain_array, 34);
        check("t6b_upd_after", gain_update, 1);
        settle();

        // Inverted thresholds: over-threshold rule takes priority.
        thr_lo = 7'd100;
        thr_hi = 7'd50;
        window(8'd60);
        tick();
        check("inv_thr_gain", gain_array, 33);
        check("inv_thr_upd", gain_update, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
